// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue and its forwarding lookup.
package wb_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int REG_ADDR_W    = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [31:0]           data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_lookup.sv
// Youngest-match search over the live queue entries for one read port.
// Combinational; register 0 never hits.
module wb_fwd_lookup
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  wb_entry_t                   entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]    rptr,
  input  logic [$clog2(DEPTH):0]      count,
  input  logic [REG_ADDR_W-1:0]       read_reg,
  output logic                        hit,
  output logic [31:0]                 data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + PW'(k);
      if ((CW'(k) < count) && (read_reg != '0) && (entries[idx].rd == read_reg)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback queue to the register file with forwarding on two read ports.
// Push-to-write latency 1 cycle; in_ready = !full, rf_stall holds the head in place.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [31:0]           in_data,
  input  logic                  rf_stall,
  output logic                  rf_en,
  output logic [REG_ADDR_W-1:0] rf_write_reg,
  output logic [31:0]           rf_write_data,
  input  logic [REG_ADDR_W-1:0] read_reg1,
  input  logic [REG_ADDR_W-1:0] read_reg2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [31:0]           fwd_data1,
  output logic [31:0]           fwd_data2,
  output logic                  empty,
  output logic                  full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          push;
  logic          store;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign rf_en    = !empty && !rf_stall;

  // Writes to r0 complete the handshake but are dropped.
  assign push  = in_valid && in_ready;
  assign store = push && (in_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (store) wptr <= wptr + 1'b1;
      if (rf_en) rptr <= rptr + 1'b1;
      case ({store, rf_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[wptr] <= '{rd: in_rd, data: in_data};
  end

  assign rf_write_reg  = empty ? '0 : mem[rptr].rd;
  assign rf_write_data = empty ? '0 : mem[rptr].data;

  wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd1 (
    .entries  (mem),
    .rptr     (rptr),
    .count    (count),
    .read_reg (read_reg1),
    .hit      (fwd_hit1),
    .data     (fwd_data1)
  );

  wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd2 (
    .entries  (mem),
    .rptr     (rptr),
    .count    (count),
    .read_reg (read_reg2),
    .hit      (fwd_hit2),
    .data     (fwd_data2)
  );

endmodule
